showcase0_operand_feeder: RTL and testbench



---
 rtl/showcase0_operand_feeder_pkg.sv | 38 +++
 rtl/showcase0_operand_feeder_fifo.sv | 63 ++++++
 rtl/showcase0_operand_feeder.sv | 125 ++++++++++++
 tb/tb_showcase0_operand_feeder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/showcase0_operand_feeder_pkg.sv
// Shared types for the Showcase0 operand feeder: operand record layout,
// feeder FSM states and a helper that assembles a record from its fields.
package showcase0_pkg;

   localparam int A_W = 32;
   localparam int B_W = 32;
   localparam int I_W = 2;

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic [I_W-1:0] i;
      logic           e;
   } opnd_t;

   localparam int OPND_W = $bits(opnd_t);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      APPLY = 1'b1
   } state_t;

   // b travels as raw bits; signedness is a downstream interpretation.
   function automatic opnd_t opnd_pack(
      input logic [A_W-1:0] a,
      input logic [B_W-1:0] b,
      input logic [I_W-1:0] i,
      input logic           e
   );
      opnd_t r;
      r.a = a;
      r.b = b;
      r.i = i;
      r.e = e;
      return r;
   endfunction

endpackage

// File: rtl/showcase0_operand_feeder_fifo.sv
// Generic DEPTH x W synchronous FIFO with a combinational head read and an
// explicit occupancy count; push while full and pop while empty are ignored.
module showcase0_operand_fifo
   import showcase0_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = OPND_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == LVL_W'(0));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= PTR_W'(0);
         rd_ptr <= PTR_W'(0);
         level  <= LVL_W'(0);
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/showcase0_operand_feeder.sv
// Buffers operand sets from a valid/ready stream and applies each one to
// Showcase0 as registered levels for HOLD cycles, with a sample strobe.
module showcase0_operand_feeder
   import showcase0_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int HOLD      = 3,
   parameter int SAMPLE_AT = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  din_a,
   input  logic [31:0]                  din_b,
   input  logic [1:0]                   din_i,
   input  logic                         din_e,
   input  logic                         din_vld,
   output logic                         din_rd,
   output logic [31:0]                  a,
   output logic [31:0]                  b,
   output logic [1:0]                   i,
   output logic                         e,
   output logic                         out_vld,
   output logic                         sample_stb,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HOLD - 1);
   localparam logic [HC_W-1:0] HC_SAMPLE = HC_W'(SAMPLE_AT);

   state_t            state;
   state_t            state_nxt;
   logic [HC_W-1:0]   hold_cnt;
   logic [HC_W-1:0]   hold_cnt_nxt;
   logic              load;
   logic              push;
   logic              full;
   logic              empty;
   logic [OPND_W-1:0] head_bits;
   opnd_t             head;
   opnd_t             din_word;

   assign din_rd   = !rst && !full;
   assign push     = din_vld && din_rd;
   assign din_word = opnd_pack(din_a, din_b, din_i, din_e);
   assign head     = opnd_t'(head_bits);

   showcase0_operand_fifo #(
      .DEPTH (DEPTH),
      .W     (OPND_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (load),
      .din   (din_word),
      .dout  (head_bits),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Next-state logic: a set is loaded from IDLE, or on the last hold cycle
   // so that back-to-back sets have no gap.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      load         = 1'b0;
      case (state)
         IDLE: begin
            hold_cnt_nxt = HC_W'(0);
            if (!empty) begin
               load      = 1'b1;
               state_nxt = APPLY;
            end else begin
               state_nxt = IDLE;
            end
         end
         APPLY: begin
            if (hold_cnt == HC_LAST) begin
               hold_cnt_nxt = HC_W'(0);
               if (!empty) begin
                  load      = 1'b1;
                  state_nxt = APPLY;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + HC_W'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = HC_W'(0);
         end
      endcase
   end

   // State, hold counter and registered outputs; strobe is derived from the
   // next values so it lines up with the hold_cnt it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= HC_W'(0);
         a          <= 32'd0;
         b          <= 32'd0;
         i          <= 2'd0;
         e          <= 1'b0;
         out_vld    <= 1'b0;
         sample_stb <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_cnt_nxt;
         out_vld    <= (state_nxt == APPLY);
         sample_stb <= (state_nxt == APPLY) && (hold_cnt_nxt == HC_SAMPLE);
         if (load) begin
            a <= head.a;
            b <= head.b;
            i <= head.i;
            e <= head.e;
         end
      end
   end

endmodule

// File: tb/tb_showcase0_operand_feeder.sv
// Randomized bench for the operand feeder: a timeline model predicts when each
// accepted set is applied, plus a directed HOLD=1 instance.
module tb_showcase0_operand_feeder;
   import showcase0_pkg::*;

   localparam int DEPTH     = 4;
   localparam int HOLD      = 3;
   localparam int SAMPLE_AT = 2;

   logic        clk;
   logic        rst;
   logic [31:0] din_a;
   logic [31:0] din_b;
   logic [1:0]  din_i;
   logic        din_e;
   logic        din_vld;
   logic        din_vld1;

   logic        o_rd, o_vld, o_stb, o_e;
   logic [31:0] o_a, o_b;
   logic [1:0]  o_i;
   logic [2:0]  o_lvl;

   logic        h_rd, h_vld, h_stb, h_e;
   logic [31:0] h_a, h_b;
   logic [1:0]  h_i;
   logic [2:0]  h_lvl;

   int tests = 0;
   int fails = 0;
   int t = 0;
   bit last_acc;

   typedef struct {
      opnd_t w;
      int    start;
   } ent_t;
   ent_t ents[$];
   int   last_start = -1000;

   showcase0_operand_feeder #(.DEPTH(DEPTH), .HOLD(HOLD), .SAMPLE_AT(SAMPLE_AT)) dut (
      .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .din_i(din_i), .din_e(din_e),
      .din_vld(din_vld), .din_rd(o_rd), .a(o_a), .b(o_b), .i(o_i), .e(o_e),
      .out_vld(o_vld), .sample_stb(o_stb), .level(o_lvl)
   );

   showcase0_operand_feeder #(.DEPTH(DEPTH), .HOLD(1), .SAMPLE_AT(0)) dut1 (
      .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .din_i(din_i), .din_e(din_e),
      .din_vld(din_vld1), .din_rd(h_rd), .a(h_a), .b(h_b), .i(h_i), .e(h_e),
      .out_vld(h_vld), .sample_stb(h_stb), .level(h_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic int model_level();
      int n = 0;
      foreach (ents[k]) if (ents[k].start > t) n++;
      return n;
   endfunction

   function automatic opnd_t rand_word();
      return opnd_pack($urandom, $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
   endfunction

   // Expected outputs after edge t: the latest set started so far is on the bus.
   task automatic check_outputs();
      opnd_t w = '0;
      bit    vld = 1'b0;
      bit    stb = 1'b0;
      for (int k = ents.size() - 1; k >= 0; k--) begin
         if (ents[k].start <= t) begin
            w = ents[k].w;
            if (t - ents[k].start < HOLD) begin
               vld = 1'b1;
               stb = ((t - ents[k].start) == SAMPLE_AT);
            end
            break;
         end
      end
      chk("a", 64'(o_a), 64'(w.a));
      chk("b", 64'(o_b), 64'(w.b));
      chk("i", 64'(o_i), 64'(w.i));
      chk("e", 64'(o_e), 64'(w.e));
      chk("out_vld", 64'(o_vld), 64'(vld));
      chk("sample_stb", 64'(o_stb), 64'(stb));
      chk("level", 64'(o_lvl), 64'(model_level()));
   endtask

   task automatic cycle(input bit v, input opnd_t w, input bit r, input bit v1);
      bit exp_rd;
      int s;
      @(negedge clk);
      rst      = r;
      din_vld  = v;
      din_vld1 = v1;
      din_a    = w.a;
      din_b    = w.b;
      din_i    = w.i;
      din_e    = w.e;
      #1;
      exp_rd = !r && (model_level() < DEPTH);
      chk("din_rd", 64'(o_rd), 64'(exp_rd));
      if (v1) chk("h1_din_rd", 64'(h_rd), 64'd1);
      last_acc = v && exp_rd;
      @(posedge clk);
      t++;
      if (r) begin
         ents.delete();
         last_start = -1000;
      end else if (last_acc) begin
         s = (t + 1 > last_start + HOLD) ? t + 1 : last_start + HOLD;
         ents.push_back('{w: w, start: s});
         last_start = s;
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, rand_word(), 1'b0, 1'b0);
   endtask

   task automatic send(input int n, input int gap_pct, input bit seq, input int base);
      opnd_t pend[$];
      int    budget = 0;
      bit    v;
      for (int k = 0; k < n; k++) begin
         if (seq) pend.push_back(opnd_pack(32'(base + k), 32'(base + k), 2'(k), 1'(k)));
         else     pend.push_back(rand_word());
      end
      while (pend.size() > 0 && budget < 1000) begin
         v = ($urandom_range(99) >= gap_pct);
         cycle(v, pend[0], 1'b0, 1'b0);
         if (last_acc) void'(pend.pop_front());
         budget++;
      end
      if (pend.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL send_timeout observed=%0d left expected=0", pend.size());
      end
   endtask

   initial begin
      opnd_t w1[4];
      rst = 1'b1; din_vld = 1'b0; din_vld1 = 1'b0;
      din_a = 32'd0; din_b = 32'd0; din_i = 2'd0; din_e = 1'b0;

      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("h1_reset_vld", 64'(h_vld), 64'd0);
      chk("h1_reset_level", 64'(h_lvl), 64'd0);
      idle(2);

      // Single set {5, -3, 2, 1}, then outputs must hold after out_vld drops.
      cycle(1'b1, opnd_pack(32'd5, 32'hFFFF_FFFD, 2'd2, 1'b1), 1'b0, 1'b0);
      idle(6);
      chk("single_hold_a", 64'(o_a), 64'd5);
      chk("single_hold_b", 64'(o_b), 64'hFFFF_FFFD);
      chk("single_hold_i", 64'(o_i), 64'd2);
      chk("single_hold_vld", 64'(o_vld), 64'd0);

      send(4, 0, 1'b0, 0);    idle(14);
      send(6, 0, 1'b0, 0);    idle(20);
      send(12, 30, 1'b1, 0);  idle(20);
      send(40, 50, 1'b0, 0);  idle(20);

      // Reset while three sets are buffered and one is being applied.
      for (int k = 0; k < 4; k++) cycle(1'b1, rand_word(), 1'b0, 1'b0);
      chk("pre_rst_level", 64'(o_lvl), 64'd3);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_level", 64'(o_lvl), 64'd0);
      chk("post_rst_vld", 64'(o_vld), 64'd0);
      send(1, 0, 1'b0, 0);
      idle(6);

      // HOLD=1 instance: one set per cycle, strobe on every applied cycle.
      for (int k = 0; k < 4; k++) w1[k] = rand_word();
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, w1[k], 1'b0, 1'b1);
         if (k == 0) begin
            chk("h1_first_vld", 64'(h_vld), 64'd0);
         end else begin
            chk("h1_a", 64'(h_a), 64'(w1[k-1].a));
            chk("h1_b", 64'(h_b), 64'(w1[k-1].b));
            chk("h1_vld", 64'(h_vld), 64'd1);
            chk("h1_stb", 64'(h_stb), 64'd1);
         end
      end
      idle(1);
      chk("h1_last_a", 64'(h_a), 64'(w1[3].a));
      chk("h1_last_vld", 64'(h_vld), 64'd1);
      chk("h1_last_stb", 64'(h_stb), 64'd1);
      idle(1);
      chk("h1_end_vld", 64'(h_vld), 64'd0);
      chk("h1_end_stb", 64'(h_stb), 64'd0);
      chk("h1_end_a", 64'(h_a), 64'(w1[3].a));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
